multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Main sequencer for the multi-cycle MIPS datapath. Takes the opcode and funct fields from the instruction register and steps each instruction through fetch, decode, execute, memory and writeback. Drives every datapath strobe and mux select, including the 2-bit `alu_op` and the funct-source select consumed by `ALUControlUnit`. Uses a ready handshake with the shared instruction/data memory, so wait states are tolerated.

## Interface
- No parameters. Encodings are fixed by the ISA subset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; valid from DECODE onward.
- `funct` in 6: IR[5:0]; valid from DECODE onward.
- `mem_ready` in 1: memory completes the current read or write in this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `reg_write` out 1: datapath write strobes.
- `iord`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_dst`, `alu_src_a` out 1: memory controls and 2-way mux selects.
- `alu_src_b` out 2: ALU B-input select. 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- `alu_op` out 2: 00 = add, 01 = subtract, 10 = R-type (decoded from funct), 11 = immediate-logic (decoded from opcode).
- `funct_src` out 1: 0 sends IR funct to `ALUControlUnit`; 1 sends the opcode.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A (for JR).
- `instr_done` out 1: one-cycle pulse on the final cycle of each instruction.
- `halted` out 1: illegal opcode trapped; stays high until reset.

## Operation
- The controller is a Moore FSM. Outputs decode from the state register only, except that strobes marked "on ready" are additionally ANDed with `mem_ready`. Every output not listed for a state is 0.
- Opcodes handled: R 000000, J 000010, BEQ 000100, ADDI 001000, ADDIU 001001, ORI 001101, LUI 001111, LW 100011, SW 101011. JR is R-type with funct 001000.
- **IDLE**: all outputs 0. Goes to FETCH unconditionally.
- **FETCH**: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_write` are asserted on ready.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- **DECODE**: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (computes the branch target). Next state by opcode:
  - LW/SW → MEMADR
  - R with funct 001000 → JR
  - other R → REXEC
  - BEQ → BEQ
  - J → JUMP
  - ADDI/ADDIU → IEXEC_ADD
  - ORI/LUI → IEXEC_LOG
  - any other opcode → HALT
- **MEMADR**: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEMRD for LW, MEMWR for SW.
- **MEMRD**: `mem_read`=1, `iord`=1. Waits on `mem_ready`, then goes to MEMWB.
- **MEMWB**: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Goes to FETCH.
- **MEMWR**: `mem_write`=1, `iord`=1. Waits on `mem_ready`; `instr_done` is asserted on ready. Then goes to FETCH.
- **REXEC**: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10, `funct_src`=0. Goes to RWB.
- **RWB**: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Goes to FETCH.
- **IEXEC_ADD**: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to IWB.
- **IEXEC_LOG**: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11, `funct_src`=1. Goes to IWB.
- **IWB**: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. Goes to FETCH.
- **BEQ**: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1. Goes to FETCH.
- **JUMP**: `pc_write`=1, `pc_source`=10, `instr_done`=1. Goes to FETCH.
- **JR**: `pc_write`=1, `pc_source`=11, `instr_done`=1. Goes to FETCH.
- **HALT**: `halted`=1, all strobes 0. Terminal state; only reset leaves it.

## Timing
- While `rst_n`=0 the state is IDLE and every output is 0, including `halted`. This holds even if reset is asserted mid-instruction; an in-flight memory access is abandoned.
- The first FETCH cycle is the second rising edge after `rst_n` deasserts.
- With `mem_ready` held at 1, instruction cycle counts are:
  - BEQ, J, JR: 3
  - R-type, ADDI/ADDIU, ORI/LUI, SW: 4
  - LW: 5
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
  - `mem_read` or `mem_write` stays high for the whole wait.
  - `ir_write`, `pc_write` and `instr_done` assert only in the ready cycle, never twice per instruction.
- `mem_read` and `mem_write` are never high in the same cycle.
- `pc_write` and `pc_write_cond` are never high in the same cycle.
- `instr_done` is asserted exactly once per completed instruction. It is never asserted in HALT.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.

## Test plan
- Reset and first fetch:
  - Pulse `rst_n` low in mid-MEMRD → all outputs 0 immediately.
  - After release: one IDLE cycle, then FETCH with `mem_read`=1 and `alu_src_b`=01.
- LW with memory stalls: opcode 100011, `mem_ready`=0 for 2 cycles in both FETCH and MEMRD → 9 cycles total.
  - Exactly one `ir_write` pulse and one `reg_write` pulse with `mem_to_reg`=1.
- R-type and JR:
  - funct 100001 (ADDU) → REXEC has `alu_op`=10, `funct_src`=0; RWB has `reg_dst`=1; 4 cycles.
  - funct 001000 → JR has `pc_source`=11, `pc_write`=1; 3 cycles.
- ORI, LUI, ADDI:
  - 001101 and 001111 → IEXEC_LOG has `alu_op`=11, `funct_src`=1.
  - 001000 → `alu_op`=00, `alu_src_b`=10.
  - Each takes 4 cycles with `instr_done` in IWB.
- BEQ and J:
  - 000100 → `alu_op`=01 and `pc_write_cond`=1 in cycle 3.
  - 000010 → `pc_source`=10 and `pc_write`=1 in cycle 3.
- Illegal opcode 111111 → HALT after DECODE; `halted`=1 and all strobes 0 for 20 cycles; reset clears `halted`.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multi-cycle MIPS datapath: a Moore FSM that walks each
// instruction through fetch/decode/execute/memory/writeback, stalling on mem_ready.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       reg_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       funct_src,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       halted
);

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEMADR    = 4'd3,
    S_MEMRD     = 4'd4,
    S_MEMWB     = 4'd5,
    S_MEMWR     = 4'd6,
    S_REXEC     = 4'd7,
    S_RWB       = 4'd8,
    S_IEXEC_ADD = 4'd9,
    S_IEXEC_LOG = 4'd10,
    S_IWB       = 4'd11,
    S_BEQ       = 4'd12,
    S_JUMP      = 4'd13,
    S_JR        = 4'd14,
    S_HALT      = 4'd15
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // State register; reset abandons any in-flight access and returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state selection; mem_ready only matters in the three memory states.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:   next_state_s = S_FETCH;
      S_FETCH: begin
        if (mem_ready) next_state_s = S_DECODE;
        else           next_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_R: begin
            if (funct == FN_JR) next_state_s = S_JR;
            else                next_state_s = S_REXEC;
          end
          OP_BEQ:            next_state_s = S_BEQ;
          OP_J:              next_state_s = S_JUMP;
          OP_ADDI, OP_ADDIU: next_state_s = S_IEXEC_ADD;
          OP_ORI, OP_LUI:    next_state_s = S_IEXEC_LOG;
          default:           next_state_s = S_HALT;
        endcase
      end
      S_MEMADR: begin
        // Opcode is stable for the whole instruction; anything else here is a trap.
        if (opcode == OP_LW)      next_state_s = S_MEMRD;
        else if (opcode == OP_SW) next_state_s = S_MEMWR;
        else                      next_state_s = S_HALT;
      end
      S_MEMRD: begin
        if (mem_ready) next_state_s = S_MEMWB;
        else           next_state_s = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready) next_state_s = S_FETCH;
        else           next_state_s = S_MEMWR;
      end
      S_MEMWB, S_RWB, S_IWB, S_BEQ, S_JUMP, S_JR: next_state_s = S_FETCH;
      S_REXEC:                     next_state_s = S_RWB;
      S_IEXEC_ADD, S_IEXEC_LOG:    next_state_s = S_IWB;
      S_HALT:                      next_state_s = S_HALT;
      default:                     next_state_s = S_HALT;
    endcase
  end

  // Moore output decode; write strobes in wait states are gated by mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    funct_src     = 1'b0;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    halted        = 1'b0;
    case (state_r)
      S_IDLE: begin
        halted = 1'b0;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEMADR, S_IEXEC_ADD: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_IEXEC_LOG: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        funct_src = 1'b1;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_write   = 1'b1;
        pc_source  = 2'b11;
        instr_done = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle comparison of the full
// output vector against hand-computed state encodings.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, reg_write, iord, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, alu_src_a, funct_src, instr_done, halted;
  logic [1:0] alu_src_b, alu_op, pc_source;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .reg_write(reg_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .funct_src(funct_src),
    .pc_source(pc_source), .instr_done(instr_done), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (instr_done === 1'b1) done_cnt = done_cnt + 1;

  // Bit order: pw pwc irw rw iord mr mw m2r rd asa asb[2] aop[2] fs ps[2] done halted
  logic [18:0] outs;
  assign outs = {pc_write, pc_write_cond, ir_write, reg_write, iord, mem_read, mem_write,
                 mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, funct_src, pc_source,
                 instr_done, halted};

  localparam logic [18:0] ZERO  = 19'd0;
  localparam logic [18:0] F_W   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,2'b00,1'b0,1'b0};
  localparam logic [18:0] F_R   = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,2'b00,1'b0,1'b0};
  localparam logic [18:0] DEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0,2'b00,1'b0,1'b0};
  localparam logic [18:0] MADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,2'b00,1'b0,1'b0};
  localparam logic [18:0] MRD   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0};
  localparam logic [18:0] MWB   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0};
  localparam logic [18:0] MWR_W = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0};
  localparam logic [18:0] MWR_R = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0};
  localparam logic [18:0] REX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,1'b0,2'b00,1'b0,1'b0};
  localparam logic [18:0] RWB   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0};
  localparam logic [18:0] IADD  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,2'b00,1'b0,1'b0};
  localparam logic [18:0] ILOG  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b11,1'b1,2'b00,1'b0,1'b0};
  localparam logic [18:0] IWB   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0};
  localparam logic [18:0] BEQ   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,2'b01,1'b1,1'b0};
  localparam logic [18:0] JMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b10,1'b1,1'b0};
  localparam logic [18:0] JR    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,1'b1,1'b0};
  localparam logic [18:0] HLT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b1};

  task automatic check(input string tag, input logic [18:0] exp);
    vectors = vectors + 1;
    assert (outs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %b expected %b", tag, outs, exp);
    end
  endtask

  // Drive mem_ready for the current cycle, compare, then advance to 2ns past the next edge.
  task automatic cyc(input string tag, input logic mr, input logic [18:0] exp);
    mem_ready = mr;
    #1;
    check(tag, exp);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000; funct = 6'b000000;
    repeat (2) @(posedge clk);
    #3;
    check("in_reset", ZERO);

    // Release just after an edge: this cycle is IDLE, the next is FETCH.
    rst_n = 1'b1;
    cyc("idle", 1'b1, ZERO);

    // LW with two stall cycles in FETCH and in MEMRD: 9 cycles.
    opcode = 6'b100011; funct = 6'b000000;
    cyc("lw_fetch_w0", 1'b0, F_W);
    cyc("lw_fetch_w1", 1'b0, F_W);
    cyc("lw_fetch_rdy", 1'b1, F_R);
    cyc("lw_decode", 1'b0, DEC);
    cyc("lw_memadr", 1'b0, MADR);
    cyc("lw_memrd_w0", 1'b0, MRD);
    cyc("lw_memrd_w1", 1'b0, MRD);
    cyc("lw_memrd_rdy", 1'b1, MRD);
    cyc("lw_memwb", 1'b0, MWB);

    // ADDU (R-type)
    opcode = 6'b000000; funct = 6'b100001;
    cyc("addu_fetch", 1'b1, F_R);
    cyc("addu_decode", 1'b1, DEC);
    cyc("addu_rexec", 1'b0, REX);
    cyc("addu_rwb", 1'b0, RWB);

    // JR
    funct = 6'b001000;
    cyc("jr_fetch", 1'b1, F_R);
    cyc("jr_decode", 1'b0, DEC);
    cyc("jr_exec", 1'b0, JR);

    // ORI, LUI, ADDI
    opcode = 6'b001101; funct = 6'b000000;
    cyc("ori_fetch", 1'b1, F_R);
    cyc("ori_decode", 1'b1, DEC);
    cyc("ori_exec", 1'b0, ILOG);
    cyc("ori_wb", 1'b1, IWB);
    opcode = 6'b001111;
    cyc("lui_fetch", 1'b1, F_R);
    cyc("lui_decode", 1'b1, DEC);
    cyc("lui_exec", 1'b1, ILOG);
    cyc("lui_wb", 1'b0, IWB);
    opcode = 6'b001000;
    cyc("addi_fetch", 1'b1, F_R);
    cyc("addi_decode", 1'b1, DEC);
    cyc("addi_exec", 1'b0, IADD);
    cyc("addi_wb", 1'b1, IWB);

    // SW with one stall in MEMWR
    opcode = 6'b101011;
    cyc("sw_fetch", 1'b1, F_R);
    cyc("sw_decode", 1'b1, DEC);
    cyc("sw_memadr", 1'b1, MADR);
    cyc("sw_memwr_w0", 1'b0, MWR_W);
    cyc("sw_memwr_rdy", 1'b1, MWR_R);

    // BEQ and J
    opcode = 6'b000100;
    cyc("beq_fetch", 1'b1, F_R);
    cyc("beq_decode", 1'b1, DEC);
    cyc("beq_exec", 1'b0, BEQ);
    opcode = 6'b000010;
    cyc("j_fetch", 1'b1, F_R);
    cyc("j_decode", 1'b1, DEC);
    cyc("j_exec", 1'b1, JMP);

    // Reset asserted mid-MEMRD: outputs drop immediately, access abandoned.
    opcode = 6'b100011;
    cyc("lw2_fetch", 1'b1, F_R);
    cyc("lw2_decode", 1'b1, DEC);
    cyc("lw2_memadr", 1'b1, MADR);
    mem_ready = 1'b0;
    #1;
    check("lw2_memrd_w0", MRD);
    rst_n = 1'b0;
    #1;
    check("rst_mid_memrd", ZERO);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc("idle2", 1'b1, ZERO);
    cyc("fetch_after_rst", 1'b0, F_W);

    // Illegal opcode traps in HALT, ignoring mem_ready.
    opcode = 6'b111111;
    cyc("ill_fetch", 1'b1, F_R);
    cyc("ill_decode", 1'b1, DEC);
    for (int i = 0; i < 20; i++) cyc("halt_hold", (i % 2 == 0) ? 1'b1 : 1'b0, HLT);
    rst_n = 1'b0;
    #1;
    check("halt_reset", ZERO);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    opcode = 6'b000000;
    cyc("idle3", 1'b1, ZERO);
    cyc("fetch3", 1'b1, F_R);

    // LW, ADDU, JR, ORI, LUI, ADDI, SW, BEQ, J each complete once.
    vectors = vectors + 1;
    assert (done_cnt == 9) else begin
      miscompares = miscompares + 1;
      $error("FAIL instr_done_count: observed %0d expected %0d", done_cnt, 9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
